// File: rtl/dht11_display_pkg.sv
// Shared types and constants for the DHT11 display driver:
// FSM state encoding, common-anode segment codes, word field positions
// and the shift-add-3 step used by the BCD engine.
package dht11_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Active-low segment codes {dp,g,f,e,d,c,b,a}, dp off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Field positions inside the 32-bit reader word
  localparam int HUM_INT_LSB   = 24;
  localparam int HUM_DEC_LSB   = 16;
  localparam int TEMP_INT_LSB  = 8;
  localparam int TEMP_DEC_LSB  = 0;
  localparam int TEMP_SIGN_BIT = 7;

  // One double-dabble step: correct every nibble >= 5, then shift in bit_in
  function automatic logic [11:0] bcd_step(input logic [11:0] b, input logic bit_in);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < 3; i++) begin
      if (b[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return (a << 1) | {11'd0, bit_in};
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low 7-segment code, with blank,
// minus and decimal-point controls. Minus has priority over blank.
module seg7_encode
  import dht11_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       minus,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] code;

  // Digit lookup, then override for minus/blank, then dp on bit 7
  always_comb begin
    case (bcd)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    if (minus)      code = SEG_MINUS;
    else if (blank) code = SEG_BLANK;
    seg = {code[7] & ~dp, code[6:0]};
  end

endmodule

// File: rtl/dht11_display_driver.sv
// DHT11 display driver: detects changes of the reader word, converts the
// clamped temperature/humidity integers to BCD with an 8-step shift-add-3
// engine, and scans a 4-digit common-anode display (temp on 3..2, hum on 1..0).
// Optional macro DHT11_DISPLAY_TEMP_SIGN_EN: show a minus on digit 3 when the
// temperature sign bit is set, with the magnitude clamped to 9.
//
// Handshake: there is no strobe. A conversion starts whenever the registered
// input differs from the shadow of the last converted word while idle; a change
// seen during a conversion sets a single pending flag that re-runs the
// conversion on the then-current input. busy covers LOAD/SHIFT/DONE and
// conv_done pulses for one cycle as the display registers take the new value.
module dht11_display_driver
  import dht11_display_pkg::*;
#(
  parameter int SCAN_DIV  = 50_000,
  parameter int CLAMP_MAX = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_valid,
  output logic [7:0]  seg,
  output logic [3:0]  dig_sel,
  output logic        busy,
  output logic        conv_done
);

`ifdef DHT11_DISPLAY_TEMP_SIGN_EN
  localparam logic SIGN_EN = 1'b1;
`else
  localparam logic SIGN_EN = 1'b0;
`endif

  localparam int         CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [7:0] CLAMP_V = 8'(CLAMP_MAX);

  state_t        state;
  logic [31:0]   in_q;
  logic [31:0]   shadow;
  logic          pending;
  logic [2:0]    iter;
  logic [7:0]    hum_sr, temp_sr;
  logic [11:0]   hum_bcd, temp_bcd;
  logic [7:0]    disp_hum, disp_temp;
  logic          disp_neg;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;

  logic [7:0]    hum_clamp, temp_clamp;
  logic [3:0]    dig_bcd;
  logic          dig_blank, dig_minus, dig_dp;
  logic [7:0]    seg_code;

  assign busy = (state != ST_IDLE);

  // Input register; the only change detector is in_q versus shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= 32'd0;
    else        in_q <= data_valid;
  end

  // Clamp integers before conversion; a negative temperature keeps one digit
  always_comb begin
    hum_clamp  = in_q[HUM_INT_LSB +: 8];
    temp_clamp = in_q[TEMP_INT_LSB +: 8];
    if (hum_clamp > CLAMP_V)  hum_clamp  = CLAMP_V;
    if (temp_clamp > CLAMP_V) temp_clamp = CLAMP_V;
    if (SIGN_EN && in_q[TEMP_SIGN_BIT] && (temp_clamp > 8'd9)) temp_clamp = 8'd9;
  end

  // Conversion FSM and BCD engine; display registers change only in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shadow    <= 32'd0;
      pending   <= 1'b0;
      iter      <= 3'd0;
      hum_sr    <= 8'd0;
      temp_sr   <= 8'd0;
      hum_bcd   <= 12'd0;
      temp_bcd  <= 12'd0;
      disp_hum  <= 8'd0;
      disp_temp <= 8'd0;
      disp_neg  <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_q != shadow) state <= ST_LOAD;
        end
        ST_LOAD: begin
          shadow   <= in_q;
          hum_sr   <= hum_clamp;
          temp_sr  <= temp_clamp;
          hum_bcd  <= 12'd0;
          temp_bcd <= 12'd0;
          iter     <= 3'd0;
          state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          hum_bcd  <= bcd_step(hum_bcd, hum_sr[7]);
          temp_bcd <= bcd_step(temp_bcd, temp_sr[7]);
          hum_sr   <= hum_sr << 1;
          temp_sr  <= temp_sr << 1;
          iter     <= iter + 3'd1;
          if (in_q != shadow) pending <= 1'b1;
          if (iter == 3'd7)   state   <= ST_DONE;
        end
        ST_DONE: begin
          disp_hum  <= hum_bcd[7:0];
          disp_temp <= temp_bcd[7:0];
          disp_neg  <= SIGN_EN & shadow[TEMP_SIGN_BIT];
          conv_done <= 1'b1;
          if (pending) begin
            pending <= 1'b0;
            state   <= ST_LOAD;
          end else begin
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Digit dwell counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Digit mux: pick the nibble and its blank/minus/dp controls for idx
  always_comb begin
    dig_bcd   = 4'd0;
    dig_blank = 1'b0;
    dig_minus = 1'b0;
    dig_dp    = 1'b0;
    case (idx)
      2'd0: dig_bcd = disp_hum[3:0];
      2'd1: begin
        dig_bcd   = disp_hum[7:4];
        dig_blank = (disp_hum[7:4] == 4'd0);
      end
      2'd2: begin
        dig_bcd = disp_temp[3:0];
        dig_dp  = 1'b1;
      end
      default: begin
        dig_bcd   = disp_temp[7:4];
        dig_blank = (disp_temp[7:4] == 4'd0);
        dig_minus = disp_neg;
      end
    endcase
  end

  seg7_encode u_seg7_encode (
    .bcd   (dig_bcd),
    .blank (dig_blank),
    .minus (dig_minus),
    .dp    (dig_dp),
    .seg   (seg_code)
  );

  // Register segments and digit enable together so they switch in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= 8'hFF;
      dig_sel <= 4'hF;
    end else begin
      seg     <= seg_code;
      dig_sel <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_dht11_display_driver.sv
// Self-checking bench for dht11_display_driver (SCAN_DIV shortened to 4).
// Expected display contents come from decimal arithmetic on the applied word.
module tb_dht11_display_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_valid;
  logic [7:0]  seg;
  logic [3:0]  dig_sel;
  logic        busy;
  logic        conv_done;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int done_cnt = 0;

  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  dht11_display_driver #(.SCAN_DIV(4), .CLAMP_MAX(99)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .busy       (busy),
    .conv_done  (conv_done)
  );

  // Clock
  always #5 clk = ~clk;

  // Count conversion-complete pulses
  always @(negedge clk) if (conv_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what digit k must show for a converted word w
  function automatic logic [7:0] exp_seg(input int k, input logic [31:0] w);
    int  hum, temp;
    bit  neg;
    hum  = int'(w[31:24]);
    temp = int'(w[15:8]);
    if (hum > 99)  hum  = 99;
    if (temp > 99) temp = 99;
`ifdef DHT11_DISPLAY_TEMP_SIGN_EN
    neg = w[7];
    if (neg && temp > 9) temp = 9;
`else
    neg = 1'b0;
`endif
    case (k)
      0:       return seg_tbl[hum % 10];
      1:       return (hum / 10 == 0) ? 8'hFF : seg_tbl[hum / 10];
      2:       return seg_tbl[temp % 10] & 8'h7F;
      default: return neg ? 8'hBF : ((temp / 10 == 0) ? 8'hFF : seg_tbl[temp / 10]);
    endcase
  endfunction

  // Bounded wait for busy, then count cycles from LOAD to conv_done
  task automatic wait_conv(output int lat);
    int n;
    lat = 999;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (busy === 1'b1) begin
      n = 0;
      while (conv_done !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      if (conv_done === 1'b1) lat = n;
    end
  endtask

  // Walk the four scan slots and check each digit
  task automatic check_disp(input string tag, input logic [31:0] w);
    logic [3:0] want;
    int n;
    for (int k = 0; k < 4; k++) begin
      want = ~(4'b0001 << k);
      n = 0;
      while (dig_sel !== want && n < 40) begin @(negedge clk); n++; end
      chk({tag, "_dig_sel"}, {28'd0, dig_sel}, {28'd0, want});
      chk($sformatf("%s_seg%0d", tag, k), {24'd0, seg}, {24'd0, exp_seg(k, w)});
    end
  endtask

  // Drive a new word and check latency, single pulse and display
  task automatic apply(input string tag, input logic [31:0] w);
    int lat, d0;
    @(negedge clk);
    d0 = done_cnt;
    data_valid = w;
    wait_conv(lat);
    chk({tag, "_latency"}, lat, 10);
    repeat (3) @(negedge clk);
    chk({tag, "_one_conv"}, done_cnt - d0, 1);
    check_disp(tag, w);
  endtask

  initial begin
    logic [31:0] cur, v1, w;
    int d0, n, lat;

    // Reset
    rst_n = 1'b0;
    data_valid = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_seg", {24'd0, seg}, 32'hFF);
    chk("rst_dig_sel", {28'd0, dig_sel}, 32'hF);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_conv_done", {31'd0, conv_done}, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("idle_no_conv", done_cnt, 0);
    check_disp("zero", 32'd0);

    // Directed patterns
    apply("h45_t25", 32'h2D00_1900);
    apply("hum_clamp", 32'h7800_1900);
    apply("blank_tens", 32'h0800_0500);
    apply("sign_bit", 32'h0800_0380);
    apply("both_clamp", 32'hFF00_FF00);
    cur = 32'hFF00_FF00;

    // Dwell: each digit enabled for SCAN_DIV cycles
    n = 0;
    while (dig_sel !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (dig_sel !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (dig_sel === 4'b1110 && n < 20) begin @(negedge clk); n++; end
    chk("dwell", n, 4);

    // Same value rewritten: no conversion
    d0 = done_cnt;
    @(negedge clk);
    data_valid = cur;
    repeat (30) @(negedge clk);
    chk("same_value", done_cnt - d0, 0);

    // Two changes during one conversion: exactly two conversions, last value shown
    v1 = 32'h1700_0C00;
    d0 = done_cnt;
    @(negedge clk);
    data_valid = v1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    data_valid = v1 ^ 32'h0100_0000;
    repeat (2) @(negedge clk);
    data_valid = v1 ^ 32'h0200_0200;
    repeat (60) @(negedge clk);
    chk("pending_two_conv", done_cnt - d0, 2);
    check_disp("pending", v1 ^ 32'h0200_0200);
    cur = v1 ^ 32'h0200_0200;

    // Reset in the middle of SHIFT
    @(negedge clk);
    data_valid = 32'h3300_2200;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_seg", {24'd0, seg}, 32'hFF);
    chk("midrst_dig_sel", {28'd0, dig_sel}, 32'hF);
    chk("midrst_busy", {31'd0, busy}, 0);
    data_valid = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("post_rst_no_conv", done_cnt - d0, 0);
    check_disp("post_rst", 32'd0);
    cur = 32'd0;

    // Random words, biased half the time toward small and signed temperatures
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        w[15:8] = 8'($urandom_range(0, 30));
        w[31:24] = 8'($urandom_range(0, 120));
      end
      if (w == cur) w = w ^ 32'h0000_0001;
      apply($sformatf("rand%0d", i), w);
      cur = w;
    end

    // Latency again after random traffic, from a fresh change
    @(negedge clk);
    data_valid = cur ^ 32'h0001_0000;
    wait_conv(lat);
    chk("final_latency", lat, 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
